// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a valid/ready byte interface and sticky error flags.
//
// Frames are 8N1 (LSB first) by default. Defining UART_RX_PARITY_EN switches to 8E1:
// a PARITY state samples one extra bit, the o_parity_err port appears, and a byte
// with bad parity is dropped instead of delivered.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   rxd          serial line, idle high, asynchronous to clk
//   o_data       received byte, stable while o_valid is high
//   o_valid      o_data holds an unconsumed byte
//   i_ready      consumer takes o_data when o_valid & i_ready
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a byte was dropped because o_data was still full
//   o_parity_err sticky: parity mismatch (only with UART_RX_PARITY_EN)
//   i_clr_err    one-cycle pulse clearing all sticky flags; a same-cycle set wins
//
// Parameter CLK_DIVIDER: clk cycles per bit, must be >= 4.

module uart_rx #(
    parameter int unsigned CLK_DIVIDER = 48
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    input  logic       i_clr_err
);

    localparam int unsigned CntW = $clog2(CLK_DIVIDER);
    localparam logic [CntW-1:0] CntFull = CntW'(CLK_DIVIDER - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIVIDER / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            deliver_q, deliver_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_meta_q, rxs_q;
    logic            tick;
    logic            frame_set;
    logic            overrun_set;
`ifdef UART_RX_PARITY_EN
    logic            parity_err_q, parity_err_d;
    logic            parity_bad_q, parity_bad_d;
    logic            parity_set;
`endif

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    assign tick = (cnt_q == '0);

    // Frame FSM: next state, bit timing and shift register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_set   = 1'b0;
`endif

        if (state_q != StIdle && state_q != StBreak) begin
            cnt_d = cnt_q - CntW'(1);
        end

        case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    cnt_d   = CntHalf;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rxs_q) begin
                        // Start bit gone high at its midpoint: treat as a glitch.
                        state_d = StIdle;
                    end else begin
                        cnt_d     = CntFull;
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = CntFull;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    cnt_d        = CntFull;
                    state_d      = StStop;
                    // Even parity: data bits XOR parity bit must be zero.
                    parity_bad_d = (^shift_q) ^ rxs_q;
                    parity_set   = parity_bad_d;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                        deliver_d = !parity_bad_q;
`else
                        deliver_d = 1'b1;
`endif
                        state_d   = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a break is not re-read as frames.
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output holding register, handshake and sticky flags.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;

        if (deliver_q) begin
            // shift_q is stable here: the FSM sits in IDLE/START during delivery.
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        frame_err_d = (frame_err_q && !i_clr_err) || frame_set;
        overrun_d   = (overrun_q && !i_clr_err) || overrun_set;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q && !i_clr_err) || parity_set;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            parity_bad_q <= parity_bad_d;
        end
    end

    assign o_parity_err = parity_err_q;
`endif

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIVIDER=48: a vector table of single frames
// plus hand-written sequences for latency, back-to-back, glitch, framing error,
// overrun, reset and (with UART_RX_PARITY_EN) parity.

module tb_uart_rx;

    localparam int unsigned Div = 48;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif
    // Start edge at the pin to o_valid: sync + half bit + remaining bits to stop sample + 1.
    localparam int unsigned ExpLat = 2 + Div / 2 + (FrameBits - 1) * Div + 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
    logic       par_bad = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];

    uart_rx #(.CLK_DIVIDER(Div)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rxd         (rxd),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .i_clr_err   (i_clr_err)
    );

    always #5 clk = ~clk;

    // Record every accepted byte (sampled mid-cycle, before the accepting edge).
    always @(negedge clk) begin
        if (o_valid && i_ready) got_q.push_back(o_data);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(Div);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_bad);
`endif
        send_bit(stop_bit);
        rxd = 1'b1;
    endtask

    // Consume any pending byte and clear sticky flags.
    task automatic drain();
        i_ready = 1'b1;
        wait_clk(1);
        i_ready = 1'b0;
        i_clr_err = 1'b1;
        wait_clk(1);
        i_clr_err = 1'b0;
    endtask

    int n;
    bit seen;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h12, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

        // Reset state
        wait_clk(3);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_ferr", 32'(o_frame_err), 32'd0);
        check("rst_ovr", 32'(o_overrun), 32'd0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", 32'(o_parity_err), 32'd0);
`endif
        resetn = 1'b1;
        wait_clk(5);

        // Latency of a single 0xA5 frame, i_ready low
        n = 0;
        seen = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!seen && n < 700) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (o_valid) seen = 1'b1;
                end
            end
        join
        check("lat_seen", 32'(seen), 32'd1);
        check($sformatf("lat_window n=%0d", n),
              32'((n >= int'(ExpLat) - 1) && (n <= int'(ExpLat) + 1)), 32'd1);
        check("lat_data", 32'(o_data), 32'hA5);
        check("lat_ferr", 32'(o_frame_err), 32'd0);
        check("lat_ovr", 32'(o_overrun), 32'd0);
        i_ready = 1'b1;
        wait_clk(1);
        i_ready = 1'b0;
        check("lat_consumed", 32'(o_valid), 32'd0);
        wait_clk(Div);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            wait_clk(Div);
            check($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_data", i), 32'(o_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_ferr", i), 32'(o_frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_ovr", i), 32'(o_overrun), 32'd0);
            i_ready = 1'b1;
            wait_clk(1);
            i_ready = 1'b0;
            check($sformatf("v%0d_consumed", i), 32'(o_valid), 32'd0);
            i_clr_err = 1'b1;
            wait_clk(1);
            i_clr_err = 1'b0;
            check($sformatf("v%0d_ferr_clr", i), 32'(o_frame_err), 32'd0);
        end

        // Back-to-back frames with i_ready held high
        got_q.delete();
        i_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(Div);
        i_ready = 1'b0;
        check("b2b_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("b2b_0", 32'(got_q[0]), 32'h55);
            check("b2b_1", 32'(got_q[1]), 32'h00);
            check("b2b_2", 32'(got_q[2]), 32'hFF);
        end
        check("b2b_ferr", 32'(o_frame_err), 32'd0);
        check("b2b_ovr", 32'(o_overrun), 32'd0);

        // 10-cycle low glitch, then a real frame
        rxd = 1'b0;
        wait_clk(10);
        rxd = 1'b1;
        wait_clk(100);
        check("glitch_valid", 32'(o_valid), 32'd0);
        check("glitch_ferr", 32'(o_frame_err), 32'd0);
        check("glitch_ovr", 32'(o_overrun), 32'd0);
        send_frame(8'h3C, 1'b1);
        wait_clk(Div);
        check("glitch_next_valid", 32'(o_valid), 32'd1);
        check("glitch_next_data", 32'(o_data), 32'h3C);
        drain();

        // Framing error followed by a long break, then a good frame
        send_frame(8'h12, 1'b0);
        rxd = 1'b0;
        wait_clk(20 * Div);
        rxd = 1'b1;
        wait_clk(Div);
        check("brk_ferr", 32'(o_frame_err), 32'd1);
        check("brk_valid", 32'(o_valid), 32'd0);
        send_frame(8'h34, 1'b1);
        wait_clk(Div);
        check("brk_next_valid", 32'(o_valid), 32'd1);
        check("brk_next_data", 32'(o_data), 32'h34);
        i_clr_err = 1'b1;
        wait_clk(1);
        i_clr_err = 1'b0;
        check("brk_clr", 32'(o_frame_err), 32'd0);
        drain();

        // Clear pulse coinciding with the stop-bit sample: set wins
        fork
            send_frame(8'h12, 1'b0);
            begin
                wait_clk(ExpLat - 1);
                i_clr_err = 1'b1;
                wait_clk(1);
                i_clr_err = 1'b0;
            end
        join
        wait_clk(Div);
        check("setwins_ferr", 32'(o_frame_err), 32'd1);
        check("setwins_valid", 32'(o_valid), 32'd0);
        drain();

        // Overrun: second byte lost, first kept
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(Div);
        check("ovr_flag", 32'(o_overrun), 32'd1);
        check("ovr_data", 32'(o_data), 32'h11);
        check("ovr_valid", 32'(o_valid), 32'd1);
        drain();
        check("ovr_clr", 32'(o_overrun), 32'd0);

        // i_ready exactly in the delivery cycle of the second byte: no overrun
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_clk(ExpLat);
                i_ready = 1'b1;
                wait_clk(1);
                i_ready = 1'b0;
            end
        join
        wait_clk(Div);
        check("swap_data", 32'(o_data), 32'h22);
        check("swap_valid", 32'(o_valid), 32'd1);
        check("swap_ovr", 32'(o_overrun), 32'd0);

        // Asynchronous reset during bit 4 of a frame (o_valid/o_data are nonzero here)
        fork
            send_frame(8'h99, 1'b1);
            begin
                wait_clk(Div * 5 + Div / 2);
                #2 resetn = 1'b0;
                #1;
                check("mid_rst_valid", 32'(o_valid), 32'd0);
                check("mid_rst_data", 32'(o_data), 32'd0);
                check("mid_rst_ferr", 32'(o_frame_err), 32'd0);
                check("mid_rst_ovr", 32'(o_overrun), 32'd0);
                wait_clk(2);
                resetn = 1'b1;
            end
        join
        // Whatever the tail of the cut frame decodes to is flushed before the next test.
        wait_clk(1000);
        drain();
        send_frame(8'h7E, 1'b1);
        wait_clk(Div);
        check("post_rst_valid", 32'(o_valid), 32'd1);
        check("post_rst_data", 32'(o_data), 32'h7E);
        drain();

`ifdef UART_RX_PARITY_EN
        // Wrong parity: flag set and byte dropped
        par_bad = 1'b1;
        send_frame(8'h07, 1'b1);
        par_bad = 1'b0;
        wait_clk(Div);
        check("par_err", 32'(o_parity_err), 32'd1);
        check("par_valid", 32'(o_valid), 32'd0);
        i_clr_err = 1'b1;
        wait_clk(1);
        i_clr_err = 1'b0;
        check("par_clr", 32'(o_parity_err), 32'd0);
        send_frame(8'h07, 1'b1);
        wait_clk(Div);
        check("par_good_valid", 32'(o_valid), 32'd1);
        check("par_good_data", 32'(o_data), 32'h07);
        check("par_good_err", 32'(o_parity_err), 32'd0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
